// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage and the decode-side consumers
// of the IF/ID register (state encoding, NOP word, instruction field positions).
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } if_state_e;

    // sll $0,$0,0 -- decodes as a harmless write to $0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/if_skid_buffer.sv
// Single-entry {instr, pc4} holding slot for a fetch that completes while the
// pipeline is stalled; flush has priority over load.
module if_skid_buffer
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic        buf_valid,
    output logic [31:0] buf_instr,
    output logic [31:0] buf_pc4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc4_d   = pc4_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign buf_valid = valid_q;
    assign buf_instr = instr_q;
    assign buf_pc4   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time, and holds the IF/ID register that feeds the Control decoder.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  Rt
);

    import if_pkg::*;

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        drop_q, drop_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        buf_load, buf_flush, buf_valid;
    logic [31:0] buf_instr, buf_pc4;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    if_skid_buffer u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .flush     (buf_flush),
        .instr_in  (imem_rdata),
        .pc4_in    (pc_plus4),
        .buf_valid (buf_valid),
        .buf_instr (buf_instr),
        .buf_pc4   (buf_pc4)
    );

    // Redirect outranks every other event; a redirect with a request still in
    // flight keeps the old address on the bus and discards its response later.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        buf_load     = 1'b0;
        buf_flush    = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = BUSY;
                if (redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                end
            end
            BUSY: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    buf_flush    = 1'b1;
                    if (imem_ready) begin
                        req_addr_d = redirect_pc;
                        drop_d     = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (!imem_ready) begin
                    if (!stall) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP_INSTR;
                    end
                end else if (drop_q) begin
                    drop_d     = 1'b0;
                    req_addr_d = pc_q;
                end else if (!stall) begin
                    ifid_instr_d = imem_rdata;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    req_addr_d   = pc_plus4;
                end else begin
                    buf_load   = 1'b1;
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    req_addr_d   = redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    buf_flush    = 1'b1;
                    state_d      = BUSY;
                end else if (!stall) begin
                    ifid_instr_d = buf_instr;
                    ifid_pc4_d   = buf_pc4;
                    ifid_valid_d = buf_valid;
                    buf_flush    = 1'b1;
                    state_d      = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            drop_q       <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            drop_q       <= drop_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req   = (state_q == BUSY);
    assign imem_addr  = req_addr_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign Op         = ifid_instr_q[OP_MSB:OP_LSB];
    assign Funct      = ifid_instr_q[FUNCT_MSB:FUNCT_LSB];
    assign Rt         = ifid_instr_q[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: drives imem/stall/redirect cycle by cycle and
// compares the registered outputs against hand-computed values.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPc4;
    logic        ifidValid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;

    int checkCount = 0;
    int passCount  = 0;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_ready  (imemReady),
        .imem_rdata  (imemRdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .ifid_instr  (ifidInstr),
        .ifid_pc4    (ifidPc4),
        .ifid_valid  (ifidValid),
        .Op          (op),
        .Funct       (funct),
        .Rt          (rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Set inputs for the coming edge, then settle 1 time unit past it.
    task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic stl,
                                 input logic redir, input logic [31:0] rpc);
        imemReady  = rdy;
        imemRdata  = rdata;
        stall      = stl;
        redirect   = redir;
        redirectPc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        imemReady  = 1'b0;
        imemRdata  = 32'h0;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;

        #12;
        checkOutput("reset_req", {31'h0, imemReq}, 32'h0);
        checkOutput("reset_addr", imemAddr, 32'h0);
        checkOutput("reset_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("reset_pc4", ifidPc4, 32'h0);
        checkOutput("reset_instr", ifidInstr, 32'h0);
        reset = 1'b1;

        // IDLE -> BUSY, first request at RESET_PC
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("first_req", {31'h0, imemReq}, 32'h1);
        checkOutput("first_addr", imemAddr, 32'h0);

        applyStimulus(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0);
        checkOutput("i0_instr", ifidInstr, 32'h2008_0005);
        checkOutput("i0_pc4", ifidPc4, 32'h4);
        checkOutput("i0_valid", {31'h0, ifidValid}, 32'h1);
        checkOutput("i0_op", {26'h0, op}, 32'h08);
        checkOutput("i0_next_addr", imemAddr, 32'h4);

        applyStimulus(1'b1, 32'h2009_0007, 1'b0, 1'b0, 32'h0);
        checkOutput("i1_instr", ifidInstr, 32'h2009_0007);
        checkOutput("i1_pc4", ifidPc4, 32'h8);
        checkOutput("i1_rt", {27'h0, rt}, 32'h9);
        checkOutput("i1_next_addr", imemAddr, 32'h8);

        // Response lands during stall: parked in the skid buffer, no request in HOLD
        applyStimulus(1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_hold_instr", ifidInstr, 32'h2009_0007);
            checkOutput("stall_hold_pc4", ifidPc4, 32'h8);
            checkOutput("stall_no_req", {31'h0, imemReq}, 32'h0);
            if (i < 2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("unstall_instr", ifidInstr, 32'h0000_0020);
        checkOutput("unstall_pc4", ifidPc4, 32'hC);
        checkOutput("unstall_funct", {26'h0, funct}, 32'h20);
        checkOutput("unstall_req", {31'h0, imemReq}, 32'h1);
        checkOutput("unstall_addr", imemAddr, 32'hC);

        applyStimulus(1'b1, 32'h0109_5020, 1'b0, 1'b0, 32'h0);
        checkOutput("i3_instr", ifidInstr, 32'h0109_5020);
        checkOutput("i3_addr", imemAddr, 32'h10);

        // Redirect while the fetch to 0x10 is still pending
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        checkOutput("redir_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("redir_instr", ifidInstr, 32'h0);
        checkOutput("redir_addr_stable", imemAddr, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_wait_addr", imemAddr, 32'h10);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        checkOutput("stale_dropped_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("stale_dropped_instr", ifidInstr, 32'h0);
        checkOutput("redir_target_addr", imemAddr, 32'h100);
        applyStimulus(1'b1, 32'h8C08_0000, 1'b0, 1'b0, 32'h0);
        checkOutput("target_instr", ifidInstr, 32'h8C08_0000);
        checkOutput("target_pc4", ifidPc4, 32'h104);
        checkOutput("target_op", {26'h0, op}, 32'h23);

        // Redirect coinciding with imem_ready under stall: no drop cycle
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h100);
        checkOutput("same_cyc_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("same_cyc_addr", imemAddr, 32'h100);
        checkOutput("same_cyc_req", {31'h0, imemReq}, 32'h1);
        applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0);
        checkOutput("same_cyc_next_instr", ifidInstr, 32'hAAAA_0001);
        checkOutput("same_cyc_next_pc4", ifidPc4, 32'h104);

        // PC wrap from 0xFFFF_FFFC
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap_redir_addr", imemAddr, 32'h104);
        applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_fetch_addr", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 32'h2442_0001, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_instr", ifidInstr, 32'h2442_0001);
        checkOutput("wrap_pc4", ifidPc4, 32'h0);
        checkOutput("wrap_next_addr", imemAddr, 32'h0);

        // Second redirect while drop is pending: only the newest target is fetched
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        checkOutput("double_redir_addr", imemAddr, 32'h0);
        applyStimulus(1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
        checkOutput("double_redir_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("double_redir_target", imemAddr, 32'h300);
        applyStimulus(1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0);
        checkOutput("pre_reset_pc4", ifidPc4, 32'h304);

        // Asynchronous reset mid-BUSY, checked before any clock edge
        imemReady = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_req", {31'h0, imemReq}, 32'h0);
        checkOutput("async_addr", imemAddr, 32'h0);
        checkOutput("async_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("async_pc4", ifidPc4, 32'h0);
        checkOutput("async_instr", ifidInstr, 32'h0);

        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        // Late ready at the IDLE edge must be ignored
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        checkOutput("rel_addr", imemAddr, 32'h0);
        checkOutput("rel_req", {31'h0, imemReq}, 32'h1);
        checkOutput("rel_valid", {31'h0, ifidValid}, 32'h0);
        checkOutput("rel_instr", ifidInstr, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rel_wait_addr", imemAddr, 32'h0);
        checkOutput("rel_wait_valid", {31'h0, ifidValid}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
